// File: rtl/div_recon_pkg.sv
// rtl/div_recon_pkg.sv - shared types, widths and saturating add for the dividend reconstruction checker
package div_recon_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int W_DEF = 8;
  localparam int CNT_W = 16;
  localparam int SUM_W = 32;

  // Adds in SUM_W+1 bits and clamps to limit; narrower counters pass a zero-extended limit.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b,
                                               input logic [SUM_W-1:0] limit);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, limit}) return limit;
    return s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/div_recon_stats.sv
// rtl/div_recon_stats.sv - running error statistics: sample count, error sum and error maximum
module div_recon_stats
  import div_recon_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic               clr_stats,
  input  logic [2*W-1:0]     err_abs,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*W-1:0]     err_max
);

  localparam logic [SUM_W-1:0] CNT_LIM = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] SUM_LIM = {SUM_W{1'b1}};

  // Clear has priority over a coinciding sample, which is then dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_sum    <= '0;
      err_max    <= '0;
    end else if (clr_stats) begin
      sample_cnt <= '0;
      err_sum    <= '0;
      err_max    <= '0;
    end else if (sample) begin
      sample_cnt <= CNT_W'(sat_add(SUM_W'(sample_cnt), SUM_W'(1), CNT_LIM));
      err_sum    <= sat_add(err_sum, SUM_W'(err_abs), SUM_LIM);
      if (err_abs > err_max) err_max <= err_abs;
    end
  end

endmodule

// File: rtl/div_reconstruct_seq.sv
// rtl/div_reconstruct_seq.sv - rebuilds q*d+r with a W-step shift-add and reports error against the reference dividend
module div_reconstruct_seq
  import div_recon_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       q,
  input  logic [W-1:0]       d,
  input  logic [W-1:0]       r,
  input  logic [2*W-1:0]     n_ref,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     n_out,
  output logic [2*W-1:0]     err_abs,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*W-1:0]     err_max
);

  localparam int STEP_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W-1);

  state_t              state, next_state;
  logic [STEP_W-1:0]   step;
  logic [W-1:0]        q_reg, d_reg;
  logic [2*W-1:0]      nref_reg;
  logic [2*W-1:0]      acc, addend, acc_next;
  logic                sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MUL;
      end
      MUL: begin
        if (step == LAST_STEP) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign addend   = q_reg[step] ? ({{W{1'b0}}, d_reg} << step) : '0;
  assign acc_next = acc + addend;
  assign sample   = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step     <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      nref_reg <= '0;
      acc      <= '0;
      n_out    <= '0;
      err_abs  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= q;
            d_reg    <= d;
            nref_reg <= n_ref;
            acc      <= {{W{1'b0}}, r};
            step     <= '0;
          end
        end
        MUL: begin
          acc  <= acc_next;
          step <= step + STEP_W'(1);
          // Result registers only move on the final step, so they hold through DONE.
          if (step == LAST_STEP) begin
            n_out   <= acc_next;
            err_abs <= (acc_next >= nref_reg) ? (acc_next - nref_reg) : (nref_reg - acc_next);
          end
        end
        default: ;
      endcase
    end
  end

  div_recon_stats #(.W(W)) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (sample),
    .clr_stats  (clr_stats),
    .err_abs    (err_abs),
    .sample_cnt (sample_cnt),
    .err_sum    (err_sum),
    .err_max    (err_max)
  );

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// tb/tb_div_reconstruct_seq.sv - scoreboard bench for div_reconstruct_seq with directed vectors
module tb_div_reconstruct_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  q = '0, d = '0, r = '0;
  logic [15:0] n_ref = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] n_out, err_abs;
  logic        clr_stats = 1'b0;
  logic [15:0] sample_cnt;
  logic [31:0] err_sum;
  logic [15:0] err_max;

  typedef struct {
    logic [15:0] n;
    logic [15:0] e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  div_reconstruct_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q          (q),
    .d          (d),
    .r          (r),
    .n_ref      (n_ref),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .n_out      (n_out),
    .err_abs    (err_abs),
    .clr_stats  (clr_stats),
    .sample_cnt (sample_cnt),
    .err_sum    (err_sum),
    .err_max    (err_max)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int cnt, input int sum, input int mx);
    check({tag, ".sample_cnt"}, 32'(sample_cnt), cnt);
    check({tag, ".err_sum"}, err_sum, sum);
    check({tag, ".err_max"}, 32'(err_max), mx);
  endtask

  // Monitor: the handshake completes on the next rising edge, so the entry is popped here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("n_out", 32'(n_out), 32'(e.n));
        check("err_abs", 32'(err_abs), 32'(e.e));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [7:0] qi, input logic [7:0] di, input logic [7:0] ri,
                       input logic [15:0] nr, input logic [15:0] en, input logic [15:0] ee);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
    q = qi; d = di; r = ri; n_ref = nr; in_valid = 1'b1;
    sb.push_back('{n: en, e: ee});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_one(input string tag, input logic [7:0] qi, input logic [7:0] di,
                         input logic [7:0] ri, input logic [15:0] nr,
                         input logic [15:0] en, input logic [15:0] ee);
    int cyc;
    issue(qi, di, ri, nr, en, ee);
    wait_valid(cyc);
    check({tag, ".latency"}, cyc, 8);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 1);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.n_out", 32'(n_out), 0);
    check("rst.err_abs", 32'(err_abs), 0);
    check_stats("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    run_one("exact", 8'h0C, 8'h05, 8'h03, 16'h003F, 16'h003F, 16'h0000);
    check_stats("exact", 1, 0, 0);
    run_one("approx1", 8'h0C, 8'h05, 8'h03, 16'h0045, 16'h003F, 16'h0006);
    check_stats("approx1", 2, 6, 6);
    run_one("approx2", 8'h0C, 8'h05, 8'h03, 16'h003D, 16'h003F, 16'h0002);
    check_stats("approx2", 3, 8, 6);
    run_one("max", 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 16'h0000);
    check_stats("max", 4, 8, 6);
    run_one("dzero", 8'hAA, 8'h00, 8'h7F, 16'h0080, 16'h007F, 16'h0001);
    check_stats("dzero", 5, 9, 6);

    // Back-pressure with a competing operand set waiting on in_valid.
    out_ready = 1'b0;
    issue(8'h10, 8'h10, 8'h05, 16'h0100, 16'h0105, 16'h0005);
    wait_valid(cyc);
    check("bp.latency", cyc, 8);
    q = 8'hFF; d = 8'hFF; r = 8'hFF; n_ref = 16'h0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", 32'(out_valid), 1);
      check("bp.in_ready", 32'(in_ready), 0);
      check("bp.n_out_held", 32'(n_out), 32'h0105);
    end
    check_stats("bp_hold", 5, 9, 6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_stats("bp_done", 6, 14, 6);
    check("bp.back_to_idle", 32'(in_ready), 1);

    // Clear coinciding with a handshake.
    out_ready = 1'b0;
    issue(8'h03, 8'h07, 8'h01, 16'h0020, 16'h0016, 16'h000A);
    wait_valid(cyc);
    check("clr.latency", cyc, 8);
    out_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    check_stats("clr", 0, 0, 0);
    run_one("after_clr", 8'h02, 8'h03, 8'h00, 16'h0010, 16'h0006, 16'h000A);
    check_stats("after_clr", 1, 10, 10);

    // Reset at step 3 aborts the operation.
    issue(8'h55, 8'h33, 8'h11, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", 32'(out_valid), 0);
    check("rstmid.in_ready", 32'(in_ready), 1);
    check_stats("rstmid", 0, 0, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rstmid.no_result", seen, 0);
    run_one("post_rst", 8'h0C, 8'h05, 8'h03, 16'h003F, 16'h003F, 16'h0000);
    check_stats("post_rst", 1, 0, 0);
    check("sb_drained", sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
